// File: rtl/riscv_mem_pkg.sv
// Shared encodings and constants for the unified-memory arbiter.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int unsigned MEM_WORDS_DEFAULT = 1024;
    localparam int unsigned WORD_SHIFT        = 2;
    localparam int unsigned STRB_W            = 4;

endpackage

// File: rtl/riscv_mem_grant.sv
// Grant selection between fetch and data requesters.
// RISCV_MEM_ARB_RR_EN selects round-robin; otherwise data always wins.
module riscv_mem_grant
    import riscv_mem_pkg::*;
(
    input  logic       if_valid,
    input  logic       d_valid,
    input  logic       idle,
    input  req_id_t    last_grant,
    output logic [1:0] grant,
    output req_id_t    last_grant_next
);

    logic pick_d;

`ifdef RISCV_MEM_ARB_RR_EN
    // On contention the port that did not win last time gets the slot.
    always_comb begin
        pick_d = d_valid;
        if (if_valid && d_valid) begin
            pick_d = (last_grant == REQ_IF);
        end
    end

    assign last_grant_next = (idle && (if_valid || d_valid))
                           ? (pick_d ? REQ_D : REQ_IF) : last_grant;
`else
    logic unused_last_grant;

    assign pick_d            = d_valid;
    assign unused_last_grant = last_grant;
    assign last_grant_next   = REQ_D;
`endif

    assign grant[REQ_IF] = idle & if_valid & ~pick_d;
    assign grant[REQ_D]  = idle & d_valid & pick_d;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serialises fetch and load/store requests onto one synchronous word memory.
// Optional round-robin arbitration via RISCV_MEM_ARB_RR_EN.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_WORDS   = MEM_WORDS_DEFAULT,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         if_req_valid,
    input  logic [ADDR_W-1:0]            if_req_addr,
    output logic                         if_req_ready,
    output logic                         if_rsp_valid,
    output logic [DATA_W-1:0]            if_rsp_data,
    output logic                         if_rsp_err,
    input  logic                         d_req_valid,
    input  logic                         d_req_we,
    input  logic [ADDR_W-1:0]            d_req_addr,
    input  logic [DATA_W-1:0]            d_req_wdata,
    input  logic [STRB_W-1:0]            d_req_wstrb,
    output logic                         d_req_ready,
    output logic                         d_rsp_valid,
    output logic [DATA_W-1:0]            d_rsp_rdata,
    output logic                         d_rsp_err,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [STRB_W-1:0]            mem_wstrb,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    req_id_t           owner, owner_next;
    logic              cmd_we, cmd_we_next;
    req_id_t           last_grant, last_grant_next;
    logic [1:0]        grant;
    logic              idle;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [STRB_W-1:0] sel_wstrb;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    logic              mem_en_d, mem_we_d;
    logic [STRB_W-1:0] mem_wstrb_d;
    logic [AW-1:0]     mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              if_rsp_valid_d, if_rsp_err_d, d_rsp_valid_d, d_rsp_err_d;
    logic [DATA_W-1:0] if_rsp_data_d, d_rsp_rdata_d;

    assign idle = (state == ST_IDLE);

    riscv_mem_grant u_grant (
        .if_valid        (if_req_valid),
        .d_valid         (d_req_valid),
        .idle            (idle),
        .last_grant      (last_grant),
        .grant           (grant),
        .last_grant_next (last_grant_next)
    );

    assign if_req_ready = grant[REQ_IF];
    assign d_req_ready  = grant[REQ_D];

    // Winning request; fetches never write.
    assign sel_addr  = grant[REQ_D] ? d_req_addr : if_req_addr;
    assign sel_we    = grant[REQ_D] & d_req_we;
    assign sel_wstrb = grant[REQ_D] ? d_req_wstrb : '0;
    assign sel_wdata = grant[REQ_D] ? d_req_wdata : '0;
    assign sel_err   = (sel_addr[1:0] != 2'b00) ||
                       ((sel_addr >> WORD_SHIFT) >= ADDR_W'(MEM_WORDS));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= REQ_IF;
            cmd_we     <= 1'b0;
            last_grant <= REQ_D;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            owner      <= owner_next;
            cmd_we     <= cmd_we_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        owner_next  = owner;
        cmd_we_next = cmd_we;
        unique case (state)
            ST_IDLE: begin
                if (|grant) begin
                    owner_next  = grant[REQ_D] ? REQ_D : REQ_IF;
                    cmd_we_next = sel_we;
                    state_next  = sel_err ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                cnt_next   = CNT_W'(MEM_LATENCY - 1);
            end
            ST_WAIT: begin
                if (cnt == '0) state_next = ST_RESP;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            ST_RESP, ST_ERR: state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    // Next-cycle output values; the memory strobe and response pulses are registered.
    always_comb begin
        mem_en_d       = 1'b0;
        mem_we_d       = 1'b0;
        mem_wstrb_d    = '0;
        mem_addr_d     = '0;
        mem_wdata_d    = '0;
        if_rsp_valid_d = 1'b0;
        if_rsp_data_d  = '0;
        if_rsp_err_d   = 1'b0;
        d_rsp_valid_d  = 1'b0;
        d_rsp_rdata_d  = '0;
        d_rsp_err_d    = 1'b0;
        if (idle && state_next == ST_ISSUE) begin
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_wstrb_d = sel_wstrb;
            mem_addr_d  = AW'(sel_addr >> WORD_SHIFT);
            mem_wdata_d = sel_wdata;
        end
        if (state_next == ST_RESP) begin
            if (owner_next == REQ_D) begin
                d_rsp_valid_d = 1'b1;
                d_rsp_rdata_d = cmd_we ? '0 : mem_rdata;
            end else begin
                if_rsp_valid_d = 1'b1;
                if_rsp_data_d  = mem_rdata;
            end
        end
        if (state_next == ST_ERR) begin
            if (owner_next == REQ_D) begin
                d_rsp_valid_d = 1'b1;
                d_rsp_err_d   = 1'b1;
            end else begin
                if_rsp_valid_d = 1'b1;
                if_rsp_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_wstrb    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_rdata  <= '0;
            d_rsp_err    <= 1'b0;
        end else begin
            mem_en       <= mem_en_d;
            mem_we       <= mem_we_d;
            mem_wstrb    <= mem_wstrb_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            if_rsp_valid <= if_rsp_valid_d;
            if_rsp_data  <= if_rsp_data_d;
            if_rsp_err   <= if_rsp_err_d;
            d_rsp_valid  <= d_rsp_valid_d;
            d_rsp_rdata  <= d_rsp_rdata_d;
            d_rsp_err    <= d_rsp_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: transaction-level model predicts
// responses and memory commands, a monitor compares what the DUT presents.
module tb_riscv_mem_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned LAT       = 3;
    localparam int unsigned AW        = $clog2(MEM_WORDS);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              if_req_valid = 1'b0, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0]       if_req_addr = '0, if_rsp_data;
    logic              d_req_valid = 1'b0, d_req_we = 1'b0, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0]       d_req_addr = '0, d_req_wdata = '0, d_rsp_rdata;
    logic [3:0]        d_req_wstrb = '0;
    logic              mem_en, mem_we;
    logic [3:0]        mem_wstrb;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    riscv_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .MEM_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory environment: synchronous word RAM, read data valid LAT cycles after mem_en only.
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_pipe [LAT];
    logic [31:0] wtmp;
    assign mem_rdata = rd_pipe[LAT-1];
    always @(posedge clock) begin
        for (int i = int'(LAT) - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= 32'hBAD0_BAD0;
        if (mem_en) begin
            if (mem_we) begin
                wtmp = mem[mem_addr];
                for (int b = 0; b < 4; b++) if (mem_wstrb[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] <= wtmp;
            end else begin
                rd_pipe[0] <= mem[mem_addr];
            end
        end
    end

    // Reference model and scoreboard queues.
    typedef struct { int port; logic [31:0] data; logic err; int due; } rsp_exp_t;
    typedef struct { int due; logic [AW-1:0] addr; logic we; logic [3:0] wstrb; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic v; logic we; logic [31:0] a; logic [31:0] wd; logic [3:0] ws; } req_t;

    logic [31:0] ref_mem [MEM_WORDS];
    rsp_exp_t    rsp_q[$];
    mem_exp_t    mem_q[$];
    req_t        pif, pd;
    int          busy_until = -1;

    function automatic req_t mkreq(input logic we, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] ws);
        req_t r;
        r.v = 1'b1; r.we = we; r.a = a; r.wd = wd; r.ws = ws;
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'($urandom_range(1024, 1000000)) << 2;
        w = (r < 6) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(1020, 1023));
        return w << 2;
    endfunction

    // A handshake in the current cycle: predict the memory command and the response.
    task automatic accept(input int port, input req_t r);
        logic [31:0]   word;
        logic [AW-1:0] idx;
        logic          err;
        rsp_exp_t      e;
        mem_exp_t      m;
        word   = r.a >> 2;
        idx    = AW'(word);
        err    = (r.a[1:0] != 2'b00) || (word >= 32'(MEM_WORDS));
        e.port = port;
        e.err  = err;
        e.data = '0;
        if (err) begin
            e.due = cyc + 1;
        end else begin
            m.due   = cyc + 1;
            m.addr  = idx;
            m.we    = (port == 1) && r.we;
            m.wstrb = (port == 1) ? r.ws : 4'h0;
            m.wdata = r.wd;
            mem_q.push_back(m);
            if (m.we) begin
                for (int b = 0; b < 4; b++) if (r.ws[b]) ref_mem[idx][8*b +: 8] = r.wd[8*b +: 8];
            end else begin
                e.data = ref_mem[idx];
            end
            e.due = cyc + int'(LAT) + 2;
        end
        busy_until = e.due;
        rsp_q.push_back(e);
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic step();
        logic eif, ed;
        if_req_valid = pif.v; if_req_addr = pif.a;
        d_req_valid = pd.v; d_req_we = pd.we; d_req_addr = pd.a;
        d_req_wdata = pd.wd; d_req_wstrb = pd.ws;
        @(negedge clock);
        ed  = pd.v && (cyc > busy_until);
        eif = pif.v && !pd.v && (cyc > busy_until);
        check("d_req_ready", 64'(d_req_ready), 64'(ed));
        check("if_req_ready", 64'(if_req_ready), 64'(eif));
        if (ed) begin
            accept(1, pd);
            pd.v = 1'b0;
        end else if (eif) begin
            accept(0, pif);
            pif.v = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0 || pif.v || pd.v) && t < 60) begin
            step();
            t++;
        end
        if (rsp_q.size() != 0 || mem_q.size() != 0 || pif.v || pd.v) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending rsp %0d mem %0d", rsp_q.size(), mem_q.size());
            rsp_q.delete(); mem_q.delete(); pif.v = 1'b0; pd.v = 1'b0;
        end
    endtask

    function automatic logic outs_any();
        return |{if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err, d_req_ready, d_rsp_valid,
                 d_rsp_rdata, d_rsp_err, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata};
    endfunction

    // Monitor: compare every response pulse and memory strobe against the queues.
    rsp_exp_t me;
    mem_exp_t mm;
    always @(negedge clock) begin
        if (reset_n) begin
            if (rsp_q.size() != 0 && rsp_q[0].due < cyc) begin
                me = rsp_q.pop_front();
                check("missing_rsp", 64'(cyc), 64'(me.due));
            end
            if (mem_q.size() != 0 && mem_q[0].due < cyc) begin
                mm = mem_q.pop_front();
                check("missing_mem_en", 64'(cyc), 64'(mm.due));
            end
            if (if_rsp_valid || d_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'({if_rsp_valid, d_rsp_valid}), 64'(0));
                end else begin
                    me = rsp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(me.due));
                    check("rsp_port", 64'({if_rsp_valid, d_rsp_valid}), (me.port == 1) ? 64'(1) : 64'(2));
                    if (me.port == 1) begin
                        check("d_rsp_rdata", 64'(d_rsp_rdata), 64'(me.data));
                        check("d_rsp_err", 64'(d_rsp_err), 64'(me.err));
                    end else begin
                        check("if_rsp_data", 64'(if_rsp_data), 64'(me.data));
                        check("if_rsp_err", 64'(if_rsp_err), 64'(me.err));
                    end
                end
            end
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_en", 64'(mem_en), 64'(0));
                end else begin
                    mm = mem_q.pop_front();
                    check("mem_cycle", 64'(cyc), 64'(mm.due));
                    check("mem_addr", 64'(mem_addr), 64'(mm.addr));
                    check("mem_we", 64'(mem_we), 64'(mm.we));
                    check("mem_wstrb", 64'(mem_wstrb), 64'(mm.wstrb));
                    if (mm.we) check("mem_wdata", 64'(mem_wdata), 64'(mm.wdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
            ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
        end
        mem[3]     = 32'h00A0_0093;
        ref_mem[3] = 32'h00A0_0093;
        for (int i = 0; i < int'(LAT); i++) rd_pipe[i] = 32'hBAD0_BAD0;
        pif = '{default: '0};
        pd  = '{default: '0};

        repeat (3) @(posedge clock);
        #1 check("reset_outputs", 64'(outs_any()), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Fetch of a known instruction word.
        pif = mkreq(1'b0, 32'h0000_000C, '0, '0);
        drain();
        // Store then load back.
        pd = mkreq(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        drain();
        pd = mkreq(1'b0, 32'h0000_0040, '0, 4'h0);
        drain();
        // Misaligned load and out-of-range fetch.
        pd = mkreq(1'b0, 32'h0000_0041, '0, 4'h0);
        drain();
        pif = mkreq(1'b0, 32'h0000_1000, '0, '0);
        drain();
        // Both valid with data re-armed immediately: data keeps winning.
        pif = mkreq(1'b0, 32'h0000_0010, '0, '0);
        for (int k = 0; k < 3; k++) begin
            pd = mkreq(1'(k), 32'h0000_0044 + 32'(4 * k), $urandom, 4'(k + 3));
            for (int t = 0; t < 20 && pd.v; t++) step();
        end
        drain();

        // Reset while the transaction waits on memory.
        pd = mkreq(1'b0, 32'h0000_0040, '0, 4'h0);
        for (int t = 0; t < 20 && pd.v; t++) step();
        step();
        step();
        reset_n = 1'b0;
        #1 check("reset_mid_outputs", 64'(outs_any()), 64'(0));
        rsp_q.delete();
        mem_q.delete();
        busy_until = cyc;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (8) step();
        pd = mkreq(1'b0, 32'h0000_0040, '0, 4'h0);
        drain();

        // Randomised traffic with occasional abandoned requests.
        for (int n = 0; n < 500; n++) begin
            if (!pif.v && $urandom_range(0, 2) == 0)
                pif = mkreq(1'b0, rand_addr(), '0, '0);
            else if (pif.v && $urandom_range(0, 15) == 0)
                pif.v = 1'b0;
            if (!pd.v && $urandom_range(0, 2) == 0)
                pd = mkreq(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            else if (pd.v && $urandom_range(0, 15) == 0)
                pd.v = 1'b0;
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares the CPU's single unified word memory between two requesters: the instruction-fetch port (read-only) and the load/store data port.
- Sits between the multicycle control FSM and the memory array.
- Accepts one transaction at a time over valid/ready, drives a single-port synchronous memory with fixed read latency, and returns a one-cycle response pulse to the originating port.
- Flags misaligned and out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width of both request ports.
- DATA_W, 32, data word width; fixed at 32.
- MEM_WORDS, 1024, memory depth in words; word index >= MEM_WORDS is an error.
- MEM_LATENCY, 1, cycles from the mem_en cycle until mem_rdata is valid; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  one-cycle fetch response
- if_rsp_data  out  DATA_W  fetched word
- if_rsp_err  out  1  fetch address error
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data byte address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  4  store byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  one-cycle data response (loads and stores)
- d_rsp_rdata  out  DATA_W  load data; 0 for stores
- d_rsp_err  out  1  data address error
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_wstrb  out  4  memory byte enables
- mem_addr  out  $clog2(MEM_WORDS)  word index, byte address >> 2
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
  - Every output goes to 0, state goes to IDLE, last-grant register goes to data.
  - Reset mid-transaction drops the transaction; mem_en deasserts immediately and no response is issued.
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - The grant is combinational from the valids; the winner's req_ready is high in the same cycle and the loser's ready is 0.
  - Handshake = valid & ready. The arbiter registers addr, we, wdata, wstrb and the requester id.
  - Fixed priority: data beats fetch.
  - Next state is ISSUE, or ERR if addr[1:0] != 0 or (addr >> 2) >= MEM_WORDS.
  - Fetch requests have we=0 and wstrb=0 forced internally.
- ISSUE: mem_en=1 for exactly one cycle with the registered command. Go to WAIT with the latency counter at MEM_LATENCY-1, or straight to the capture point when MEM_LATENCY=1.
- WAIT: decrement the counter. At the end of the cycle in which mem_rdata is valid (cycle ISSUE+MEM_LATENCY), sample it and go to RESP.
- RESP:
  - Owner's rsp_valid=1 for one cycle. rsp_data is the sampled word for loads/fetches and 0 for stores; err=0. Return to IDLE.
  - Stores complete in memory at the ISSUE edge, but still get a response with the same timing.
- ERR: owner's rsp_valid=1 and err=1 for one cycle; data=0; mem_en is never asserted. Return to IDLE.
- Latency:
  - Accept in cycle 0 → rsp_valid in cycle MEM_LATENCY+2.
  - Error: accept in cycle 0 → rsp_valid in cycle 1.
  - Peak throughput is one transaction per MEM_LATENCY+3 cycles.
- Response rules:
  - There is no response backpressure; the requester must sample in the rsp_valid cycle.
  - Both req_ready signals are 0 outside IDLE.
  - A request dropped before its handshake is legal and is simply not served.
- Simultaneous valids in IDLE: the grant follows the priority rule; the loser holds valid and is served on the next IDLE.
- rsp_valid is never high on both ports in the same cycle.

Optional Feature:
- Macro RISCV_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports are valid, the grant goes to the port not granted last; the last-grant register updates on every handshake.
- Undefined: fixed data-over-fetch priority, and no last-grant register is synthesised.

Decomposition:
- Package riscv_mem_pkg holds:
  - the state encoding (IDLE/ISSUE/WAIT/RESP/ERR);
  - the requester id encoding (REQ_IF=0, REQ_D=1);
  - the MEM_WORDS default;
  - the word-address shift constant (2).
- Sub-module riscv_mem_grant:
  - inputs are the two valids, the idle flag and the last-grant state;
  - outputs are the one-hot grant and the updated last-grant;
  - it contains the priority/round-robin logic and the only RISCV_MEM_ARB_RR_EN conditional.

Test Plan:
- Fetch alone, MEM_LATENCY=1, memory word 3 = 0x00A00093: fetch addr 0x0C accepted cycle 0 → mem_en and mem_addr=3 in cycle 1; if_rsp_valid with data 0x00A00093 in cycle 3; d_rsp_valid stays 0.
- Store then load: store addr 0x40, wdata 0xDEADBEEF, wstrb 0xF → mem_we=1, mem_addr=16, d_rsp_valid cycle 3 with rdata 0. Load addr 0x40 → d_rsp_rdata 0xDEADBEEF.
- Both valid continuously:
  - Without the macro: grant order D, D, D…
  - With RISCV_MEM_ARB_RR_EN: order D, IF, D, IF.
- Errors:
  - Load addr 0x41 → d_rsp_err=1 in cycle 1, mem_en never high.
  - Fetch addr 0x1000 with MEM_WORDS=1024 → if_rsp_err=1.
- MEM_LATENCY=3: accept cycle 0 → rsp_valid cycle 5; both req_ready low in cycles 1–5.
- reset_n low during WAIT → all outputs 0 immediately; no rsp_valid after release; next request is served normally.
